hpu_seq: RTL and testbench

- Job sequencer for the HPU stream datapath; replaces host-driven toggling of the matw/run/last control bits.
- Host writes one job descriptor and a start pulse. The block drives matw for the matrix-load phase, then run/last for the block-streaming phase.
- It counts input-block completions (src_fin) and output-frame completions (TLAST handshakes), then returns the datapath to reset (run=0) and pulses done.
- Sits between the AXI-Lite register file and the src/s/exe/out control blocks, in the AXIS clock domain.

---
 rtl/hpu_seq_if.sv | 39 +++
 rtl/hpu_seq.sv | 162 ++++++++++++++++
 tb/tb_hpu_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/hpu_seq_if.sv
// Control/status bundle between the AXI-Lite register file, the stream-side
// handshake taps and the hpu_seq job sequencer.
interface hpu_seq_if #(
  parameter int CNT_W  = 16,
  parameter int MLEN_W = 10
);
  logic              start;
  logic              abort;
  logic              cfg_mat_load;
  logic [MLEN_W-1:0] cfg_mat_len;
  logic [CNT_W-1:0]  cfg_blocks;
  logic              mat_beat;
  logic              src_fin;
  logic              dst_last_beat;
  logic              matw;
  logic              run;
  logic              last;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              err;
  logic [CNT_W-1:0]  blocks_in;
  logic [CNT_W-1:0]  blocks_out;
  logic [1:0]        state;

  modport master (
    output start, abort, cfg_mat_load, cfg_mat_len, cfg_blocks,
           mat_beat, src_fin, dst_last_beat,
    input  matw, run, last, busy, done, aborted, err,
           blocks_in, blocks_out, state
  );

  modport slave (
    input  start, abort, cfg_mat_load, cfg_mat_len, cfg_blocks,
           mat_beat, src_fin, dst_last_beat,
    output matw, run, last, busy, done, aborted, err,
           blocks_in, blocks_out, state
  );
endinterface

// File: rtl/hpu_seq.sv
// HPU job sequencer: matrix-load phase, block-streaming phase, done/abort.
// Optional progress watchdog enabled by defining HPU_SEQ_WDOG_EN.
module hpu_seq #(
  parameter int CNT_W       = 16,
  parameter int MLEN_W      = 10,
  parameter int TIMEOUT_CYC = 65535
) (
  input logic       clk,
  input logic       rst,
  hpu_seq_if.slave  io_bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MAT  = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [MLEN_W-1:0] MLEN_ONE = 1;

  state_t            r_state;
  logic              r_matw, r_run, r_last, r_busy, r_done, r_aborted, r_err;
  logic [CNT_W-1:0]  r_blocks_in, r_blocks_out, r_cfg_blocks;
  logic [MLEN_W-1:0] r_mat_cnt, r_cfg_mat_len;
  logic [CNT_W-1:0]  w_in_nxt, w_out_nxt;
  logic              w_active, w_timeout;

  assign w_active = (r_state == S_MAT) || (r_state == S_RUN);

`ifdef HPU_SEQ_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] r_wdog;
  logic            w_progress;

  assign w_progress = io_bus.mat_beat | io_bus.src_fin | io_bus.dst_last_beat;
  assign w_timeout  = w_active && (r_wdog == WD_W'(TIMEOUT_CYC));

  // Cleared outside MAT/RUN, so every state entry starts the count from zero
  always_ff @(posedge clk) begin
    if (rst || !w_active || w_progress || w_timeout || io_bus.abort) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = |TIMEOUT_CYC;
  assign w_timeout    = 1'b0;
`endif

  always_comb begin
    w_in_nxt  = r_blocks_in;
    w_out_nxt = r_blocks_out;
    if (r_state == S_RUN && io_bus.src_fin && (r_blocks_in < r_cfg_blocks)) begin
      w_in_nxt = r_blocks_in + CNT_ONE;
    end
    if (r_state == S_RUN && io_bus.dst_last_beat) begin
      w_out_nxt = r_blocks_out + CNT_ONE;
    end
  end

  // Job configuration is captured only on an accepted start
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && io_bus.start) begin
      r_cfg_blocks  <= io_bus.cfg_blocks;
      r_cfg_mat_len <= io_bus.cfg_mat_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_matw       <= 1'b0;
      r_run        <= 1'b0;
      r_last       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_err        <= 1'b0;
      r_blocks_in  <= '0;
      r_blocks_out <= '0;
      r_mat_cnt    <= '0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      if (r_state != S_IDLE && io_bus.start) r_err <= 1'b1;
      if (r_state != S_IDLE && (io_bus.abort || w_timeout)) begin
        r_state <= S_IDLE;
        r_matw  <= 1'b0;
        r_run   <= 1'b0;
        r_last  <= 1'b0;
        r_busy  <= 1'b0;
        r_aborted <= 1'b1;
        if (w_timeout) r_err <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (io_bus.start) begin
              r_err        <= 1'b0;
              r_blocks_in  <= '0;
              r_blocks_out <= '0;
              r_mat_cnt    <= '0;
              if (io_bus.cfg_blocks == '0) begin
                r_err <= 1'b1;
              end else if (io_bus.cfg_mat_load && io_bus.cfg_mat_len != '0) begin
                r_state <= S_MAT;
                r_matw  <= 1'b1;
                r_busy  <= 1'b1;
              end else begin
                r_state <= S_RUN;
                r_run   <= 1'b1;
                r_busy  <= 1'b1;
                r_last  <= (io_bus.cfg_blocks == CNT_ONE);
              end
            end
          end
          S_MAT: begin
            if (io_bus.mat_beat) begin
              if (r_mat_cnt == r_cfg_mat_len - MLEN_ONE) begin
                r_state <= S_RUN;
                r_matw  <= 1'b0;
                r_run   <= 1'b1;
                r_last  <= (r_cfg_blocks == CNT_ONE);
              end else begin
                r_mat_cnt <= r_mat_cnt + MLEN_ONE;
              end
            end
          end
          S_RUN: begin
            r_blocks_in  <= w_in_nxt;
            r_blocks_out <= w_out_nxt;
            if (io_bus.dst_last_beat && w_out_nxt == r_cfg_blocks) begin
              r_state <= S_DONE;
              r_run   <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_last <= (w_in_nxt >= r_cfg_blocks - CNT_ONE);
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign io_bus.matw       = r_matw;
  assign io_bus.run        = r_run;
  assign io_bus.last       = r_last;
  assign io_bus.busy       = r_busy;
  assign io_bus.done       = r_done;
  assign io_bus.aborted    = r_aborted;
  assign io_bus.err        = r_err;
  assign io_bus.blocks_in  = r_blocks_in;
  assign io_bus.blocks_out = r_blocks_out;
  assign io_bus.state      = r_state;
endmodule

// File: tb/tb_hpu_seq.sv
// Directed bench for hpu_seq; status word is {matw,run,last,busy,done,aborted,err,state}.
module tb_hpu_seq;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  hpu_seq_if #(.CNT_W(16), .MLEN_W(10)) bus ();

  hpu_seq #(.CNT_W(16), .MLEN_W(10), .TIMEOUT_CYC(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [8:0] ST_IDLE  = 9'b0000000_00;
  localparam logic [8:0] ST_MAT   = 9'b1001000_01;
  localparam logic [8:0] ST_RUN   = 9'b0101000_10;
  localparam logic [8:0] ST_RUNL  = 9'b0111000_10;
  localparam logic [8:0] ST_DONE  = 9'b0000100_11;
  localparam logic [8:0] ST_ABORT = 9'b0000010_00;
  localparam logic [8:0] ST_ERR   = 9'b0000001_00;

  function automatic logic [8:0] st();
    return {bus.matw, bus.run, bus.last, bus.busy, bus.done, bus.aborted, bus.err, bus.state};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    bus.start = 0; bus.abort = 0; bus.mat_beat = 0; bus.src_fin = 0; bus.dst_last_beat = 0;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.abort = 0; bus.cfg_mat_load = 0; bus.cfg_mat_len = '0;
    bus.cfg_blocks = '0; bus.mat_beat = 0; bus.src_fin = 0; bus.dst_last_beat = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      bus.start = 1'($urandom); bus.abort = 1'($urandom); bus.cfg_mat_load = 1'($urandom);
      bus.cfg_mat_len = 10'($urandom); bus.cfg_blocks = 16'($urandom);
      bus.mat_beat = 1'($urandom); bus.src_fin = 1'($urandom); bus.dst_last_beat = 1'($urandom);
      tick();
    end
    total++;
    if (st() !== ST_IDLE || bus.blocks_in !== 16'd0 || bus.blocks_out !== 16'd0) begin
      bad++;
      $display("FAIL reset_state got st=%b in=%0d out=%0d exp st=%b in=0 out=0", st(), bus.blocks_in, bus.blocks_out, ST_IDLE);
    end
    idle_inputs();
    rst = 0;
    tick();
    bus.src_fin = 1; bus.dst_last_beat = 1; bus.mat_beat = 1; bus.abort = 1;
    tick();
    total++;
    if (st() !== ST_IDLE || bus.blocks_in !== 16'd0 || bus.blocks_out !== 16'd0) begin
      bad++;
      $display("FAIL idle_ignore got st=%b in=%0d out=%0d exp st=%b in=0 out=0", st(), bus.blocks_in, bus.blocks_out, ST_IDLE);
    end
  endtask

  task automatic test_mat_job();
    bus.cfg_mat_load = 1; bus.cfg_mat_len = 10'd4; bus.cfg_blocks = 16'd2; bus.start = 1;
    tick();
    total++;
    if (st() !== ST_MAT) begin bad++; $display("FAIL mat_entry got %b exp %b", st(), ST_MAT); end
    bus.cfg_blocks = 16'd7; bus.cfg_mat_len = 10'd1;
    for (int i = 0; i < 3; i++) begin bus.mat_beat = 1; tick(); end
    total++;
    if (st() !== ST_MAT) begin bad++; $display("FAIL mat_3beats got %b exp %b", st(), ST_MAT); end
    bus.mat_beat = 1; tick();
    total++;
    if (st() !== ST_RUN) begin bad++; $display("FAIL mat_to_run got %b exp %b", st(), ST_RUN); end
    bus.src_fin = 1; tick();
    total++;
    if (st() !== ST_RUNL || bus.blocks_in !== 16'd1) begin
      bad++; $display("FAIL last_rise got st=%b in=%0d exp st=%b in=1", st(), bus.blocks_in, ST_RUNL);
    end
    bus.src_fin = 1; tick();
    bus.src_fin = 1; tick();
    total++;
    if (st() !== ST_RUNL || bus.blocks_in !== 16'd2) begin
      bad++; $display("FAIL src_sat got st=%b in=%0d exp st=%b in=2", st(), bus.blocks_in, ST_RUNL);
    end
    bus.dst_last_beat = 1; tick();
    total++;
    if (st() !== ST_RUNL || bus.blocks_out !== 16'd1) begin
      bad++; $display("FAIL dst_first got st=%b out=%0d exp st=%b out=1", st(), bus.blocks_out, ST_RUNL);
    end
    bus.dst_last_beat = 1; tick();
    total++;
    if (st() !== ST_DONE || bus.blocks_in !== 16'd2 || bus.blocks_out !== 16'd2) begin
      bad++; $display("FAIL mat_done got st=%b in=%0d out=%0d exp st=%b in=2 out=2", st(), bus.blocks_in, bus.blocks_out, ST_DONE);
    end
    tick();
    total++;
    if (st() !== ST_IDLE) begin bad++; $display("FAIL done_one_cycle got %b exp %b", st(), ST_IDLE); end
  endtask

  task automatic test_single_block();
    bus.cfg_mat_load = 0; bus.cfg_blocks = 16'd1; bus.start = 1;
    tick();
    total++;
    if (st() !== ST_RUNL) begin bad++; $display("FAIL single_run got %b exp %b", st(), ST_RUNL); end
    bus.mat_beat = 1; tick();
    total++;
    if (st() !== ST_RUNL) begin bad++; $display("FAIL mat_beat_in_run got %b exp %b", st(), ST_RUNL); end
    bus.dst_last_beat = 1; tick();
    total++;
    if (st() !== ST_DONE || bus.blocks_out !== 16'd1) begin
      bad++; $display("FAIL single_done got st=%b out=%0d exp st=%b out=1", st(), bus.blocks_out, ST_DONE);
    end
    tick();
    total++;
    if (st() !== ST_IDLE) begin bad++; $display("FAIL single_idle got %b exp %b", st(), ST_IDLE); end
  endtask

  task automatic test_err();
    bus.cfg_mat_load = 1; bus.cfg_mat_len = 10'd3; bus.cfg_blocks = 16'd0; bus.start = 1;
    tick();
    total++;
    if (st() !== ST_ERR) begin bad++; $display("FAIL zero_blocks got %b exp %b", st(), ST_ERR); end
    tick();
    total++;
    if (st() !== ST_ERR) begin bad++; $display("FAIL err_sticky got %b exp %b", st(), ST_ERR); end
    bus.cfg_mat_load = 0; bus.cfg_blocks = 16'd1; bus.start = 1;
    tick();
    total++;
    if (st() !== ST_RUNL) begin bad++; $display("FAIL err_clear got %b exp %b", st(), ST_RUNL); end
    bus.start = 1; bus.cfg_blocks = 16'd5; tick();
    total++;
    if (st() !== (ST_RUNL | ST_ERR)) begin bad++; $display("FAIL start_busy got %b exp %b", st(), ST_RUNL | ST_ERR); end
    bus.dst_last_beat = 1; tick();
    total++;
    if (st() !== (ST_DONE | ST_ERR)) begin bad++; $display("FAIL busy_job_done got %b exp %b", st(), ST_DONE | ST_ERR); end
    tick();
  endtask

  task automatic test_abort();
    bus.cfg_mat_load = 0; bus.cfg_blocks = 16'd3; bus.start = 1;
    tick();
    bus.src_fin = 1; tick();
    total++;
    if (st() !== ST_RUN || bus.blocks_in !== 16'd1) begin
      bad++; $display("FAIL abort_pre got st=%b in=%0d exp st=%b in=1", st(), bus.blocks_in, ST_RUN);
    end
    bus.abort = 1; tick();
    total++;
    if (st() !== ST_ABORT || bus.blocks_in !== 16'd1) begin
      bad++; $display("FAIL abort_run got st=%b in=%0d exp st=%b in=1", st(), bus.blocks_in, ST_ABORT);
    end
    tick();
    total++;
    if (st() !== ST_IDLE || bus.blocks_in !== 16'd1) begin
      bad++; $display("FAIL abort_hold got st=%b in=%0d exp st=%b in=1", st(), bus.blocks_in, ST_IDLE);
    end
    bus.cfg_mat_load = 1; bus.cfg_mat_len = 10'd2; bus.cfg_blocks = 16'd1;
    bus.start = 1; bus.abort = 1; tick();
    total++;
    if (st() !== ST_MAT) begin bad++; $display("FAIL start_wins got %b exp %b", st(), ST_MAT); end
    bus.abort = 1; tick();
    total++;
    if (st() !== ST_ABORT) begin bad++; $display("FAIL abort_mat got %b exp %b", st(), ST_ABORT); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.cfg_mat_load = 0; bus.cfg_blocks = 16'd2; bus.start = 1;
    tick();
    bus.src_fin = 1; bus.dst_last_beat = 1; tick();
    total++;
    if (st() !== ST_RUNL || bus.blocks_in !== 16'd1 || bus.blocks_out !== 16'd1) begin
      bad++; $display("FAIL same_cycle got st=%b in=%0d out=%0d exp st=%b in=1 out=1", st(), bus.blocks_in, bus.blocks_out, ST_RUNL);
    end
    bus.src_fin = 1; bus.dst_last_beat = 1; tick();
    total++;
    if (st() !== ST_DONE || bus.blocks_in !== 16'd2 || bus.blocks_out !== 16'd2) begin
      bad++; $display("FAIL same_cycle_done got st=%b in=%0d out=%0d exp st=%b in=2 out=2", st(), bus.blocks_in, bus.blocks_out, ST_DONE);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.cfg_mat_load = 1; bus.cfg_mat_len = 10'd8; bus.cfg_blocks = 16'd4; bus.start = 1;
    tick();
    bus.start = 1; tick();
    rst = 1; tick();
    rst = 0;
    total++;
    if (st() !== ST_IDLE || bus.blocks_in !== 16'd0) begin
      bad++; $display("FAIL reset_mid got st=%b in=%0d exp st=%b in=0", st(), bus.blocks_in, ST_IDLE);
    end
  endtask

`ifdef HPU_SEQ_WDOG_EN
  task automatic test_wdog();
    int n;
    bus.cfg_mat_load = 0; bus.cfg_blocks = 16'd1; bus.start = 1;
    tick();
    n = 0;
    while (bus.aborted !== 1'b1 && n < 40) begin tick(); n++; end
    total++;
    if (n < 16 || n > 18 || st() !== (ST_ABORT | ST_ERR)) begin
      bad++; $display("FAIL wdog got st=%b after %0d cycles exp st=%b after 16..18", st(), n, ST_ABORT | ST_ERR);
    end
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_mat_job();
    test_single_block();
    test_err();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef HPU_SEQ_WDOG_EN
    test_wdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
